x_delay_line_tdc: RTL and testbench
===================================

// Module: x_delay_line_tdc
// PURPOSE
//  Parametrised tapped-delay-line time-to-digital converter. Launches an edge into a chain of NCELLS inverting LUT cells.
//  It snapshots every tap through a SYNC_STAGES resolver and thermometer-decodes how many cells the edge crossed in one clock.
//  Optionally accumulates 2**ACC_LOG2 measurements. Result is delivered on a valid/ready port to the FPGA-side consumer.
// PARAMETERS
//  NCELLS       16  number of delay cells in the chain (>=2)
//  SYNC_STAGES  2   resolver flops per tap (>=2)
//  RELAX_CYCLES 4   cycles launch held low between samples so the chain returns to rest (>=1)
//  ACC_LOG2     0   log2 of samples summed per result (0 = single shot)
//  CW           $clog2(NCELLS+1) derived count width; OW = CW+ACC_LOG2 derived result width
// PORTS
//  i_clk      in   1       single clock; all flops posedge
//  i_rst      in   1       reset, synchronous, active-high
//  i_start    in   1       request one result; sampled only in IDLE
//  i_tst_en   in   1       1 = decode i_tst_vec instead of chain snapshot (bench/BIST hook)
//  i_tst_vec  in   NCELLS  substitute snapshot, same bit order as taps (bit0 = first cell)
//  i_ready    in   1       consumer accepts result when o_valid&&i_ready
//  o_valid    out  1       result available, held until accepted
//  o_count    out  OW      summed cell count
//  o_ovf      out  1       sticky in window: some sample saw all NCELLS cells flipped
//  o_bubble   out  1       sticky in window: some snapshot was non-thermometer
//  o_busy     out  1       FSM not in IDLE
//  o_launch   out  1       registered edge driving the chain input (debug)
// BEHAVIOUR
//  - Reset (sync, i_rst=1 at edge): FSM->IDLE; launch, all tap resolver flops, snapshot, accumulator, sample counter = 0.
//    All outputs 0 from the cycle after. Reset mid-operation aborts silently; no partial result is emitted.
//  - Chain: cell k output = ~(cell k-1 output), cell0 input = launch reg. Rest pattern REST[k] = (k even), e.g. 16'h5555.
//  - Decode: F = snapshot ^ REST (1 = cell flipped); n = index of first 0 in F from bit0, or NCELLS if F all ones.
//    ovf = (n==NCELLS); bubble = |(F >> n) (ones beyond first 0). Sum width OW cannot wrap: max NCELLS<<ACC_LOG2.
//  - FSM:
//    IDLE:    i_start -> LAUNCH; clear acc, flags, sample ctr.
//    LAUNCH:  launch=1 for SYNC_STAGES+1 cycles; snapshot registered on last cycle.
//    CAPTURE: 1 cycle; acc += n; flags |= ovf/bubble; ctr++.
//    RELAX:   launch=0 for RELAX_CYCLES cycles; then ctr==2**ACC_LOG2 ? DONE : LAUNCH.
//    DONE:    o_valid=1, outputs stable; o_valid&&i_ready -> IDLE (o_valid low next cycle).
//  - Latency: i_start edge to o_valid = 1 + 2**ACC_LOG2*(SYNC_STAGES+2+RELAX_CYCLES) cycles (defaults: 9).
//  - i_start outside IDLE ignored (no queueing). i_ready with o_valid=0 ignored.
//    i_start in the same cycle as accept is ignored (FSM re-enters IDLE first).
//  - i_tst_en sampled at snapshot time only; chain still launched so timing is identical.
//  - Non-SYNTH cell model is zero-delay: all cells flip, so n = NCELLS and ovf = 1 without the test hook.
// STRUCTURE
//  - Package x_delay_line_pkg: state enum (IDLE, LAUNCH, CAPTURE, RELAX, DONE), function rest_pattern(NCELLS),
//    function therm_decode returning {n, ovf, bubble}.
//  - Sub-module x_delay_line_tap: one cell (SB_LUT4 under SYNTH, inverter otherwise) plus SYNC_STAGES resolver
//    with synchronous active-high reset. Generate NCELLS instances. FSM, decode and accumulator live in this top.
// TESTING
//  1 Reset: i_rst=1 3 cycles during LAUNCH -> next cycle o_busy=0, o_launch=0, o_valid=0, o_count=0.
//  2 Single: NCELLS=16, tst_en=1, vec=16'h5555^16'h003F, pulse i_start -> o_valid at +9, o_count=6, ovf=0, bubble=0.
//  3 Zero-delay chain, tst_en=0 -> o_count=16, o_ovf=1, o_bubble=0.
//  4 Bubble: vec=16'h5555^16'h00BF -> o_count=6, o_bubble=1; vec=16'h5555 -> o_count=0, flags 0.
//  5 Accumulate: ACC_LOG2=2, vec=16'h5555^16'h001F -> o_count=20 at +33; ovf sticky if any sample has all 16 flipped.
//  6 Backpressure: i_ready=0 10 cycles -> o_valid/o_count stable; i_start pulses ignored; accept -> IDLE, restart works.

Source files
------------

// File: rtl/x_delay_line_pkg.sv
// Shared types and helpers for the tapped-delay-line TDC: FSM states, the
// chain rest pattern and the thermometer decoder.
package x_delay_line_pkg;

  localparam int MAX_CELLS = 256;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    CAPTURE,
    RELAX,
    DONE
  } tdc_state_t;

  typedef struct packed {
    logic [15:0] n;
    logic        ovf;
    logic        bubble;
  } decode_t;

  // Idle chain alternates because every cell inverts: even cells sit at 1.
  function automatic logic [MAX_CELLS-1:0] rest_pattern(input int ncells);
    logic [MAX_CELLS-1:0] pat;
    pat = '0;
    for (int k = 0; k < MAX_CELLS; k++) begin
      if (k < ncells) pat[k] = (k % 2 == 0);
    end
    return pat;
  endfunction

  function automatic decode_t therm_decode(input logic [MAX_CELLS-1:0] flipped,
                                           input int ncells);
    decode_t res;
    logic    found;
    res.n      = 16'(ncells);
    res.ovf    = 1'b0;
    res.bubble = 1'b0;
    found      = 1'b0;
    for (int k = 0; k < MAX_CELLS; k++) begin
      if (k < ncells) begin
        if (found && flipped[k]) res.bubble = 1'b1;
        if (!found && !flipped[k]) begin
          found = 1'b1;
          res.n = 16'(k);
        end
      end
    end
    res.ovf = ~found;
    return res;
  endfunction

endpackage

// File: rtl/x_delay_line_tap.sv
// One inverting delay cell plus its metastability resolver; the resolver
// samples the cell's own output.
module x_delay_line_tap #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic cell_in,
  output logic cell_out,
  output logic tap
);

`ifdef SYNTH
  SB_LUT4 #(.LUT_INIT(16'h5555)) u_lut (
    .O (cell_out),
    .I0(cell_in),
    .I1(1'b0),
    .I2(1'b0),
    .I3(1'b0)
  );
`else
  assign cell_out = ~cell_in;
`endif

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cell_out};
    end
  end

  assign tap = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/x_delay_line_tdc.sv
// Tapped-delay-line TDC: launches an edge, snapshots every tap, decodes how far
// it travelled and optionally sums 2**ACC_LOG2 samples per result.
module x_delay_line_tdc
  import x_delay_line_pkg::*;
#(
  parameter int  NCELLS       = 16,
  parameter int  SYNC_STAGES  = 2,
  parameter int  RELAX_CYCLES = 4,
  parameter int  ACC_LOG2     = 0,
  localparam int CW           = $clog2(NCELLS + 1),
  localparam int OW           = CW + ACC_LOG2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_tst_en,
  input  logic [NCELLS-1:0] i_tst_vec,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [OW-1:0]     o_count,
  output logic              o_ovf,
  output logic              o_bubble,
  output logic              o_busy,
  output logic              o_launch
);

  localparam int NSAMP = 1 << ACC_LOG2;
  localparam int SCW   = ACC_LOG2 + 1;
  localparam int PW    = $clog2(SYNC_STAGES + RELAX_CYCLES + 2);
  localparam logic [MAX_CELLS-1:0] REST_FULL = rest_pattern(NCELLS);
  localparam logic [NCELLS-1:0]    REST      = REST_FULL[NCELLS-1:0];

  tdc_state_t        state, next_state;
  logic [PW-1:0]     phase;
  logic [SCW-1:0]    samples;
  logic              launch_q;
  logic [NCELLS-1:0] taps;
  logic [NCELLS-1:0] snapshot;
  logic [OW-1:0]     acc;
  logic              ovf_q;
  logic              bubble_q;
  logic              chain_unused;
  decode_t           dec;

  // Per-block nets keep the combinational chain free of self-referencing vectors.
  for (genvar k = 0; k < NCELLS; k++) begin : g_tap
    logic cell_in;
    logic cell_out;
    if (k == 0) begin : g_head
      assign cell_in = launch_q;
    end else begin : g_body
      assign cell_in = g_tap[k-1].cell_out;
    end
    x_delay_line_tap #(.SYNC_STAGES(SYNC_STAGES)) u_tap (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .cell_in (cell_in),
      .cell_out(cell_out),
      .tap     (taps[k])
    );
  end

  assign chain_unused = g_tap[NCELLS-1].cell_out;

  assign dec = therm_decode(MAX_CELLS'(snapshot ^ REST), NCELLS);

  always_comb begin
    next_state = state;
    o_valid    = 1'b0;
    o_busy     = 1'b1;
    unique case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) next_state = LAUNCH;
      end
      LAUNCH: begin
        if (phase == PW'(SYNC_STAGES)) next_state = CAPTURE;
      end
      CAPTURE: begin
        next_state = RELAX;
      end
      RELAX: begin
        if (phase == PW'(RELAX_CYCLES - 1))
          next_state = (samples == SCW'(NSAMP)) ? DONE : LAUNCH;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Phase restarts on every state change so LAUNCH and RELAX time themselves.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      phase    <= '0;
      samples  <= '0;
      launch_q <= 1'b0;
      snapshot <= '0;
      acc      <= '0;
      ovf_q    <= 1'b0;
      bubble_q <= 1'b0;
    end else begin
      state    <= next_state;
      phase    <= (next_state != state) ? '0 : phase + PW'(1);
      launch_q <= (next_state == LAUNCH);
      if (state == IDLE && i_start) begin
        acc      <= '0;
        ovf_q    <= 1'b0;
        bubble_q <= 1'b0;
        samples  <= '0;
      end
      if (state == LAUNCH && phase == PW'(SYNC_STAGES)) begin
        snapshot <= i_tst_en ? i_tst_vec : taps;
      end
      if (state == CAPTURE) begin
        acc      <= acc + OW'(dec.n);
        ovf_q    <= ovf_q | dec.ovf;
        bubble_q <= bubble_q | dec.bubble;
        samples  <= samples + SCW'(1);
      end
    end
  end

  assign o_count  = acc;
  assign o_ovf    = ovf_q;
  assign o_bubble = bubble_q;
  assign o_launch = launch_q;

endmodule

// File: tb/tb_x_delay_line_tdc.sv
// Bench for x_delay_line_tdc: single-shot unit driven from a vector table with a
// scoreboard, plus an accumulating unit exercised by hand-written sequences.
module tb_x_delay_line_tdc;

  logic        i_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        tst_en = 1'b0;
  logic [15:0] tst_vec = 16'h0;
  logic        ready = 1'b0;
  logic        valid, ovf, bubble, busy, launch;
  logic [4:0]  count;

  logic        a_start = 1'b0;
  logic        a_tst_en = 1'b0;
  logic [15:0] a_tst_vec = 16'h0;
  logic        a_ready = 1'b0;
  logic        a_valid, a_ovf, a_bubble, a_busy, a_launch;
  logic [6:0]  a_count;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int   count;
    logic ovf;
    logic bubble;
  } exp_t;

  typedef struct {
    string       name;
    logic        en;
    logic [15:0] flips;
    exp_t        e;
  } vec_t;

  exp_t sb[$];

  always #5 i_clk = ~i_clk;

  x_delay_line_tdc #(.NCELLS(16), .SYNC_STAGES(2), .RELAX_CYCLES(4), .ACC_LOG2(0)) dut (
    .i_clk(i_clk), .i_rst(rst), .i_start(start), .i_tst_en(tst_en), .i_tst_vec(tst_vec),
    .i_ready(ready), .o_valid(valid), .o_count(count), .o_ovf(ovf), .o_bubble(bubble),
    .o_busy(busy), .o_launch(launch)
  );

  x_delay_line_tdc #(.NCELLS(16), .SYNC_STAGES(2), .RELAX_CYCLES(4), .ACC_LOG2(2)) dut_acc (
    .i_clk(i_clk), .i_rst(rst), .i_start(a_start), .i_tst_en(a_tst_en), .i_tst_vec(a_tst_vec),
    .i_ready(a_ready), .o_valid(a_valid), .o_count(a_count), .o_ovf(a_ovf), .o_bubble(a_bubble),
    .o_busy(a_busy), .o_launch(a_launch)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one request, queues its expectation and waits (bounded) for o_valid.
  task automatic applyStimulus(input logic en, input logic [15:0] flips, input exp_t e,
                               input logic poke_start);
    int lat;
    tst_en  = en;
    tst_vec = 16'h5555 ^ flips;
    start   = 1'b1;
    sb.push_back(e);
    tick();
    start = 1'b0;
    lat   = 1;
    while (!valid && lat < 100) begin
      start = poke_start && (lat == 4);
      tick();
      lat++;
    end
    start = 1'b0;
    checkOutput("latency", lat, 9);
  endtask

  task automatic scoreboardPop();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL scoreboard: got result, expected none queued");
    end else begin
      e = sb.pop_front();
      checkOutput("count", count, e.count);
      checkOutput("ovf", ovf, e.ovf);
      checkOutput("bubble", bubble, e.bubble);
    end
  endtask

  task automatic acceptResult(input logic with_start);
    ready = 1'b1;
    start = with_start;
    tick();
    ready = 1'b0;
    start = 1'b0;
    checkOutput("valid_after_accept", valid, 0);
    checkOutput("busy_after_accept", busy, 0);
  endtask

  task automatic runAcc(input logic [15:0] first_vec, input logic [15:0] later_vec,
                        input int exp_count, input logic exp_ovf);
    int lat;
    a_tst_en  = 1'b1;
    a_tst_vec = first_vec;
    a_start   = 1'b1;
    tick();
    a_start = 1'b0;
    lat     = 1;
    while (!a_valid && lat < 200) begin
      if (lat == 5) a_tst_vec = later_vec;
      tick();
      lat++;
    end
    checkOutput("acc_latency", lat, 33);
    checkOutput("acc_count", a_count, exp_count);
    checkOutput("acc_ovf", a_ovf, exp_ovf);
    checkOutput("acc_bubble", a_bubble, 0);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    checkOutput("acc_valid_after_accept", a_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[9];
    logic seen;
    logic [4:0] held;

    tbl[0] = '{"six_cells",   1'b1, 16'h003F, '{6, 1'b0, 1'b0}};
    tbl[1] = '{"zero_delay",  1'b0, 16'h0000, '{16, 1'b1, 1'b0}};
    tbl[2] = '{"bubble",      1'b1, 16'h00BF, '{6, 1'b0, 1'b1}};
    tbl[3] = '{"rest",        1'b1, 16'h0000, '{0, 1'b0, 1'b0}};
    tbl[4] = '{"all_flipped", 1'b1, 16'hFFFF, '{16, 1'b1, 1'b0}};
    tbl[5] = '{"one_cell",    1'b1, 16'h0001, '{1, 1'b0, 1'b0}};
    tbl[6] = '{"fifteen",     1'b1, 16'h7FFF, '{15, 1'b0, 1'b0}};
    tbl[7] = '{"top_only",    1'b1, 16'h8000, '{0, 1'b0, 1'b1}};
    tbl[8] = '{"gap_at_0",    1'b1, 16'hFFFE, '{0, 1'b0, 1'b1}};

    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_launch", launch, 0);
    checkOutput("reset_count", count, 0);

    // Abort a conversion mid-LAUNCH; nothing may come out afterwards.
    tst_en  = 1'b1;
    tst_vec = 16'h5555 ^ 16'h003F;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("launch_high", launch, 1);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_launch", launch, 0);
    checkOutput("abort_valid", valid, 0);
    checkOutput("abort_count", count, 0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (valid) seen = 1'b1;
    end
    checkOutput("no_result_after_abort", seen, 0);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].en, tbl[i].flips, tbl[i].e, 1'b0);
      scoreboardPop();
      acceptResult(1'b0);
    end

    // Backpressure: result must hold while i_ready stays low, starts are ignored.
    applyStimulus(1'b1, 16'h003F, '{6, 1'b0, 1'b0}, 1'b1);
    scoreboardPop();
    held = count;
    for (int c = 0; c < 10; c++) begin
      start = c[0];
      tick();
      checkOutput("hold_valid", valid, 1);
      checkOutput("hold_count", count, {27'b0, held});
    end
    start = 1'b0;
    acceptResult(1'b1);
    tick();
    checkOutput("start_at_accept_ignored", busy, 0);
    ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    checkOutput("ready_while_idle", valid, 0);
    checkOutput("scoreboard_empty", sb.size(), 0);

    applyStimulus(1'b1, 16'h0007, '{3, 1'b0, 1'b0}, 1'b0);
    scoreboardPop();
    acceptResult(1'b0);

    runAcc(16'h5555 ^ 16'h001F, 16'h5555 ^ 16'h001F, 20, 1'b0);
    runAcc(16'hAAAA, 16'h5555 ^ 16'h001F, 31, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
